// File: rtl/rps_round_controller.sv
// One rock-paper-scissors round from player strobe to judged result.
// Asks the predictor for a move, falls back to a mod-3 pick on timeout, and keeps BCD scores.
module rps_round_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_ROUNDS     = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [1:0] move,
  output logic       pred_req,
  output logic [3:0] combination,
  input  logic       pred_valid,
  input  logic [1:0] pred_choice,
  output logic       result_valid,
  output logic [1:0] result,
  output logic [1:0] ai_move,
  output logic       timed_out,
  output logic [7:0] reward,
  output logic [7:0] player_score,
  output logic [7:0] ai_score,
  output logic [5:0] round_count,
  output logic       game_over
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
  localparam logic [5:0] MAX_VAL     = 6'(MAX_ROUNDS);
  localparam logic [1:0] MOVE_NONE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_JUDGE,
    S_REPORT,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       mv_hist_q, mv_hist_d;
  logic [1:0] fb_q, fb_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] move_q, move_d;
  logic [1:0] prev_move_q, prev_move_d;
  logic [3:0] comb_q, comb_d;
  logic [1:0] ai_choice_q, ai_choice_d;
  logic       timed_out_q, timed_out_d;
  logic [1:0] result_q, result_d;
  logic [1:0] ai_move_q, ai_move_d;
  logic [7:0] reward_q, reward_d;
  logic [7:0] pscore_q, pscore_d;
  logic [7:0] ascore_q, ascore_d;
  logic [5:0] round_q, round_d;
  logic       rise;
  logic [1:0] verdict;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // 00 tie, 01 player wins, 10 AI wins
  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] a);
    logic [1:0] r;
    if (p == a) begin
      r = 2'b00;
    end else begin
      case ({p, a})
        4'b00_01, 4'b01_10, 4'b10_00: r = 2'b01;
        default:                      r = 2'b10;
      endcase
    end
    return r;
  endfunction

  assign rise    = move_valid & ~mv_hist_q;
  assign verdict = judge(move_q, ai_choice_q);

  always_comb begin
    state_d      = state_q;
    mv_hist_d    = move_valid;
    fb_d         = (fb_q == 2'd2) ? 2'd0 : fb_q + 2'd1;
    wait_cnt_d   = wait_cnt_q;
    move_d       = move_q;
    prev_move_d  = prev_move_q;
    comb_d       = comb_q;
    ai_choice_d  = ai_choice_q;
    timed_out_d  = timed_out_q;
    result_d     = result_q;
    ai_move_d    = ai_move_q;
    reward_d     = reward_q;
    pscore_d     = pscore_q;
    ascore_d     = ascore_q;
    round_d      = round_q;
    pred_req     = 1'b0;
    result_valid = 1'b0;
    game_over    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise && move != MOVE_NONE) begin
          move_d  = move;
          // Loaded together with the move so it is already valid while pred_req is high.
          comb_d  = {prev_move_q, move};
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        pred_req   = 1'b1;
        wait_cnt_d = 8'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (pred_valid) begin
          if (pred_choice == MOVE_NONE) begin
            ai_choice_d = fb_q;
            timed_out_d = 1'b1;
          end else begin
            ai_choice_d = pred_choice;
            timed_out_d = 1'b0;
          end
          state_d = S_JUDGE;
        end else if (wait_cnt_q == TIMEOUT_VAL) begin
          ai_choice_d = fb_q;
          timed_out_d = 1'b1;
          state_d     = S_JUDGE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_JUDGE: begin
        result_d  = verdict;
        ai_move_d = ai_choice_q;
        round_d   = round_q + 6'd1;
        case (verdict)
          2'b01: begin
            reward_d = 8'hFF;
            pscore_d = bcd_inc(pscore_q);
          end
          2'b10: begin
            reward_d = 8'h01;
            ascore_d = bcd_inc(ascore_q);
          end
          default: reward_d = 8'h00;
        endcase
        state_d = S_REPORT;
      end
      S_REPORT: begin
        result_valid = 1'b1;
        prev_move_d  = move_q;
        state_d      = (round_q == MAX_VAL) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        game_over = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      // History starts high so a strobe held through reset is not seen as an edge.
      mv_hist_q   <= 1'b1;
      fb_q        <= 2'd0;
      wait_cnt_q  <= 8'd0;
      move_q      <= 2'd0;
      prev_move_q <= MOVE_NONE;
      comb_q      <= 4'b1100;
      ai_choice_q <= 2'd0;
      timed_out_q <= 1'b0;
      result_q    <= 2'd0;
      ai_move_q   <= 2'd0;
      reward_q    <= 8'd0;
      pscore_q    <= 8'd0;
      ascore_q    <= 8'd0;
      round_q     <= 6'd0;
    end else begin
      state_q     <= state_d;
      mv_hist_q   <= mv_hist_d;
      fb_q        <= fb_d;
      wait_cnt_q  <= wait_cnt_d;
      move_q      <= move_d;
      prev_move_q <= prev_move_d;
      comb_q      <= comb_d;
      ai_choice_q <= ai_choice_d;
      timed_out_q <= timed_out_d;
      result_q    <= result_d;
      ai_move_q   <= ai_move_d;
      reward_q    <= reward_d;
      pscore_q    <= pscore_d;
      ascore_q    <= ascore_d;
      round_q     <= round_d;
    end
  end

  assign combination  = comb_q;
  assign result       = result_q;
  assign ai_move      = ai_move_q;
  assign timed_out    = timed_out_q;
  assign reward       = reward_q;
  assign player_score = pscore_q;
  assign ai_score     = ascore_q;
  assign round_count  = round_q;

endmodule

// File: tb/tb_rps_round_controller.sv
// Randomized bench for rps_round_controller against a round-level game model.
// Each round is driven cycle-exactly and judged from the rock/scissors/paper rules.
module tb_rps_round_controller;

  localparam int T    = 4;
  localparam int MAXR = 12;

  logic       clock = 1'b0;
  logic       reset;
  logic       move_valid;
  logic [1:0] move;
  logic       pred_req;
  logic [3:0] combination;
  logic       pred_valid;
  logic [1:0] pred_choice;
  logic       result_valid;
  logic [1:0] result;
  logic [1:0] ai_move;
  logic       timed_out;
  logic [7:0] reward;
  logic [7:0] player_score;
  logic [7:0] ai_score;
  logic [5:0] round_count;
  logic       game_over;

  rps_round_controller #(
    .TIMEOUT_CYCLES(T),
    .MAX_ROUNDS    (MAXR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .move_valid  (move_valid),
    .move        (move),
    .pred_req    (pred_req),
    .combination (combination),
    .pred_valid  (pred_valid),
    .pred_choice (pred_choice),
    .result_valid(result_valid),
    .result      (result),
    .ai_move     (ai_move),
    .timed_out   (timed_out),
    .reward      (reward),
    .player_score(player_score),
    .ai_score    (ai_score),
    .round_count (round_count),
    .game_over   (game_over)
  );

  always #5 clock = ~clock;

  // Cycles since reset release; the fallback pick is this count mod 3.
  int cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Game model
  int         p_wins;
  int         a_wins;
  int         rounds;
  logic [1:0] prev_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int w);
    int s;
    s = (w > 99) ? 99 : w;
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  // rock 0 beats scissors 1 beats paper 2 beats rock 0
  function automatic logic [1:0] ref_result(input int p, input int a);
    if (p == a)            return 2'b00;
    if (a == (p + 1) % 3)  return 2'b01;
    return 2'b10;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    p_wins = 0;
    a_wins = 0;
    rounds = 0;
    prev_m = 2'b11;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_req"},   32'(pred_req), 32'd0);
    check_val({tag, "_comb"},  32'(combination), 32'hC);
    check_val({tag, "_rv"},    32'(result_valid), 32'd0);
    check_val({tag, "_res"},   32'(result), 32'd0);
    check_val({tag, "_ai"},    32'(ai_move), 32'd0);
    check_val({tag, "_to"},    32'(timed_out), 32'd0);
    check_val({tag, "_rew"},   32'(reward), 32'd0);
    check_val({tag, "_ps"},    32'(player_score), 32'd0);
    check_val({tag, "_as"},    32'(ai_score), 32'd0);
    check_val({tag, "_rc"},    32'(round_count), 32'd0);
    check_val({tag, "_go"},    32'(game_over), 32'd0);
  endtask

  task automatic do_reset(input logic hold_strobe);
    reset       = 1'b1;
    move_valid  = hold_strobe;
    move        = 2'b00;
    pred_valid  = 1'b0;
    pred_choice = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    tick();
    check_reset_values("rst");
    tick();
    check_val("rst_held_req", 32'(pred_req), 32'd0);
    move_valid = 1'b0;
  endtask

  // mode 0: predictor answers ch at WAIT cycle d; mode 1: answers 11 at d; mode 2: silent
  task automatic play_round(input logic [1:0] m, input int mode, input int d, input logic [1:0] ch);
    logic [1:0] exp_ai;
    logic       exp_to;
    logic [1:0] r;
    logic [7:0] exp_rew;
    exp_ai = 2'b00;
    exp_to = 1'b0;
    move_valid = 1'b0;
    tick();
    move       = m;
    move_valid = 1'b1;
    tick();
    if (m == 2'b11) begin
      check_val("inv_req", 32'(pred_req), 32'd0);
      tick();
      check_val("inv_req2", 32'(pred_req), 32'd0);
      move_valid = 1'b0;
      $display("[TB] invalid move strobe ignored");
      return;
    end
    check_val("pred_req", 32'(pred_req), 32'd1);
    check_val("combination", 32'(combination), 32'({prev_m, m}));
    // Responses outside WAIT must be ignored.
    pred_valid  = 1'($urandom_range(0, 1));
    pred_choice = 2'($urandom);
    tick();
    pred_valid = 1'b0;
    check_val("req_pulse", 32'(pred_req), 32'd0);
    for (int j = 0; j <= T; j++) begin
      move_valid  = 1'($urandom_range(0, 1));
      pred_choice = 2'($urandom);
      if (mode != 2 && j == d) begin
        pred_valid  = 1'b1;
        pred_choice = (mode == 1) ? 2'b11 : ch;
        exp_ai      = (mode == 1) ? 2'(cyc % 3) : ch;
        exp_to      = (mode == 1);
        tick();
        pred_valid = 1'b0;
        break;
      end
      if (mode == 2 && j == T) begin
        exp_ai = 2'(cyc % 3);
        exp_to = 1'b1;
        tick();
        break;
      end
      tick();
    end
    move_valid = 1'b0;
    check_val("early_rv", 32'(result_valid), 32'd0);
    tick();
    r = ref_result(int'(m), int'(exp_ai));
    rounds++;
    if (r == 2'b01) p_wins++;
    if (r == 2'b10) a_wins++;
    exp_rew = (r == 2'b10) ? 8'h01 : (r == 2'b01) ? 8'hFF : 8'h00;
    check_val("result_valid", 32'(result_valid), 32'd1);
    check_val("result", 32'(result), 32'(r));
    check_val("ai_move", 32'(ai_move), 32'(exp_ai));
    check_val("timed_out", 32'(timed_out), 32'(exp_to));
    check_val("reward", 32'(reward), 32'(exp_rew));
    check_val("player_score", 32'(player_score), 32'(to_bcd(p_wins)));
    check_val("ai_score", 32'(ai_score), 32'(to_bcd(a_wins)));
    check_val("round_count", 32'(round_count), 32'(rounds));
    prev_m = m;
    $display("[TB] round %0d move=%0d ai=%0d mode=%0d result=%0d score P%0h-A%0h",
             rounds, m, exp_ai, mode, r, player_score, ai_score);
    tick();
    check_val("rv_pulse", 32'(result_valid), 32'd0);
    check_val("game_over", 32'(game_over), 32'(rounds == MAXR));
  endtask

  task automatic try_done();
    move_valid = 1'b0;
    tick();
    move       = 2'($urandom_range(0, 2));
    move_valid = 1'b1;
    tick();
    check_val("done_req", 32'(pred_req), 32'd0);
    tick();
    check_val("done_go", 32'(game_over), 32'd1);
    check_val("done_rc", 32'(round_count), 32'(MAXR));
    move_valid = 1'b0;
    $display("[TB] strobe in DONE ignored");
  endtask

  task automatic reset_mid_round();
    logic seen_rv;
    move_valid = 1'b0;
    tick();
    move       = 2'b00;
    move_valid = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check_reset_values("midrst");
    seen_rv = 1'b0;
    for (int i = 0; i < T + 6; i++) begin
      tick();
      if (result_valid || pred_req) seen_rv = 1'b1;
    end
    check_val("midrst_no_pulse", 32'(seen_rv), 32'd0);
    move_valid = 1'b0;
    $display("[TB] reset during WAIT aborted the round");
  endtask

  initial begin
    reset       = 1'b1;
    move_valid  = 1'b0;
    move        = 2'b00;
    pred_valid  = 1'b0;
    pred_choice = 2'b00;
    model_clear();

    do_reset(1'b1);
    play_round(2'b00, 0, 1, 2'b10);
    play_round(2'b10, 0, 0, 2'b00);
    play_round(2'b01, 2, 0, 2'b00);
    play_round(2'b00, 1, 3, 2'b00);
    play_round(2'b11, 0, 0, 2'b00);
    play_round(2'b10, 0, T, 2'b01);
    reset_mid_round();

    for (int i = 0; i < 10; i++) begin
      logic [1:0] pm;
      pm = 2'($urandom_range(0, 2));
      play_round(pm, 0, $urandom_range(0, T), 2'((int'(pm) + 1) % 3));
    end
    check_val("ten_wins", 32'(player_score), 32'h10);
    while (rounds < MAXR) begin
      play_round(2'($urandom_range(0, 2)), $urandom_range(0, 2), $urandom_range(0, T),
                 2'($urandom_range(0, 2)));
    end
    try_done();
    try_done();

    for (int g = 0; g < 3; g++) begin
      do_reset(1'($urandom_range(0, 1)));
      while (rounds < MAXR) begin
        play_round(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, T),
                   2'($urandom_range(0, 2)));
      end
      try_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rps_round_controller.md
Name: rps_round_controller

Overview:
- Game-side initiator for the move predictor; owns one rock-paper-scissors round end to end.
- Latches the player's move and issues a request carrying the move-history combination.
- Collects the predictor's choice, falling back to a free-running mod-3 pick if the predictor does not answer in time.
- Judges the round, keeps BCD scores and the round count, and emits a signed reward for the learning blocks.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles allowed before the fallback choice is used (1..255).
- MAX_ROUNDS, 60: rounds per game; the controller enters DONE after this many rounds (1..63).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- move_valid  in  1  player strobe (level); only its rising edge starts a round.
- move  in  2  player move: 00 rock, 01 scissors, 10 paper, 11 invalid.
- pred_req  out  1  one-cycle request pulse to the predictor.
- combination  out  4  {prev_move, move}; prev_move = 11 when there is no history.
- pred_valid  in  1  predictor response strobe.
- pred_choice  in  2  predictor's move, same encoding as move.
- result_valid  out  1  one-cycle pulse when result, scores and reward are updated.
- result  out  2  00 tie, 01 player wins, 10 AI wins.
- ai_move  out  2  move the AI played in the last round.
- timed_out  out  1  1 when the last round used the fallback choice.
- reward  out  8  two's complement: +1 AI win, -1 (8'hFF) AI loss, 0 tie.
- player_score  out  8  two BCD digits, saturating at 99.
- ai_score  out  8  two BCD digits, saturating at 99.
- round_count  out  6  rounds completed.
- game_over  out  1  high while in DONE.

Behaviour:
- Reset values:
  - All outputs 0, except combination = 4'b1100.
  - State IDLE, prev_move = 11.
  - Edge detector history = 1, so a strobe held through reset does not start a round.
  - Fallback counter = 0.
- Fallback counter: free-running mod-3 (0, 1, 2, 0, ...), advancing every cycle including during reset release.
- Rules: rock beats scissors, scissors beat paper, paper beats rock; equal moves tie.
- IDLE:
  - Rising edge of move_valid with move != 11 latches move; next state REQUEST.
  - Rising edge with move = 11 is ignored; stays IDLE.
- REQUEST:
  - pred_req = 1 for exactly this cycle; combination = {prev_move, latched move}.
  - Wait counter cleared; next state WAIT.
  - combination holds its value until the next REQUEST.
- WAIT:
  - pred_valid is accepted only in this state; it is ignored in every other state.
  - pred_valid = 1: capture pred_choice. If pred_choice = 11, substitute the fallback value and set timed_out = 1; otherwise timed_out = 0. Next state JUDGE.
  - Otherwise the wait counter increments. When it reaches TIMEOUT_CYCLES, capture the fallback value, set timed_out = 1, next state JUDGE.
  - pred_valid in the same cycle the counter reaches TIMEOUT_CYCLES: pred_valid wins.
- JUDGE (one cycle): compute the result and the next scores.
- REPORT (one cycle):
  - result_valid = 1; result, ai_move, reward, scores and round_count are updated this cycle and held until the next REPORT.
  - prev_move is set to the latched move.
  - Next state DONE if round_count == MAX_ROUNDS, else IDLE.
- Latency:
  - Edge seen in IDLE at cycle 0 -> pred_req at cycle 1.
  - pred_valid accepted at cycle k -> result_valid at cycle k+2.
  - Timeout path -> result_valid at cycle 2 + TIMEOUT_CYCLES + 2.
- Scores: BCD increment with carry (09 -> 10); 99 stays 99. round_count does not saturate before MAX_ROUNDS.
- DONE: game_over = 1; move_valid is ignored; only reset leaves DONE.
- move_valid rising edges in any state other than IDLE are dropped, not queued.
- Reset mid-round (any state): returns to IDLE next cycle with reset values; no result_valid pulse for the aborted round.

Test Plan:
- Reset, then move = 00 with a rising edge; predictor returns 10 two cycles after pred_req -> combination = 1100, result = 10, reward = 8'h01, ai_score = 8'h01, result_valid exactly once.
- Second round move = 10, predictor 00 -> combination = 0010, result = 01, reward = 8'hFF, player_score = 8'h01.
- Predictor silent with TIMEOUT_CYCLES = 4 -> result_valid at cycle 8 after the edge, timed_out = 1, ai_move equals the sampled fallback value.
- pred_choice = 11 -> substituted with the fallback value, timed_out = 1; move = 11 strobe -> no pred_req.
- Ten player wins -> player_score = 8'h10; with MAX_ROUNDS = 3, the third result_valid is followed by game_over = 1 and further strobes are ignored.
- Reset asserted in WAIT -> next cycle IDLE, scores 0, combination = 1100, no result_valid pulse.
